// File: rtl/fp_mul_arbiter_if.sv
// Requester / multiplier bus of fp_mul_arbiter.
// slave modport: the arbiter. master modport: requesters plus the multiplier.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          hold;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [DATA_WIDTH-1:0]         mul_result;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          busy;

    modport slave (
        input  req_valid, req_a, req_b, hold, mul_result,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, hold, mul_result,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier among NUM_REQ
// requesters. Each product is steered back to its owner by a tag pipeline
// that runs alongside the operand register and the multiplier stages.
// Build option: define FP_MUL_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.
// rst_n is asynchronous and active-high despite its name.
module fp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_arbiter_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]                    rr_ptr;
    logic                             found;
    logic [IW-1:0]                    win;
    logic                             grant;
    logic [NUM_REQ-1:0]               ready_vec;
    logic [DATA_WIDTH-1:0]            mul_a_q;
    logic [DATA_WIDTH-1:0]            mul_b_q;
    // stage 0 rides with mul_a/mul_b, stage MUL_LATENCY aligns with mul_result
    logic [MUL_LATENCY:0]             tag_vld;
    logic [MUL_LATENCY:0][IW-1:0]     tag_id;
    logic [NUM_REQ-1:0]               rsp_valid_q;
    logic [DATA_WIDTH-1:0]            rsp_data_q;

    // search req_valid from rr_ptr upward with wrap; first valid index wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            int idx;
            idx = int'(rr_ptr) + n;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // a grant is always a handshake since the winner is valid by construction
    assign grant = found && !bus.hold && !rst_n;

    // one-hot ready for the winner only
    always_comb begin
        ready_vec = '0;
        if (grant) ready_vec[win] = 1'b1;
    end

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // pointer moves one past the granted requester
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end
`endif

    // operand register feeding the multiplier; holds when nothing is granted
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (grant) begin
            mul_a_q <= bus.req_a[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            mul_b_q <= bus.req_b[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // tag pipeline shifts every cycle; no stall path exists
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[MUL_LATENCY-1:0], grant};
            tag_id  <= {tag_id[MUL_LATENCY-1:0], win};
        end
    end

    // register the product and strobe its owner; data holds otherwise
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tag_vld[MUL_LATENCY] ?
                           (NUM_REQ'(1) << tag_id[MUL_LATENCY]) : '0;
            if (tag_vld[MUL_LATENCY]) rsp_data_q <= bus.mul_result;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (|tag_vld) || (|rsp_valid_q);
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed scenarios plus random
// traffic against a cycle-indexed reference model of grants and responses.
module tb_fp_mul_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LAT = 2;
    // drive cycle k -> handshake at edge k+1 -> response visible in cycle k+4
    localparam int RSP_DLY = LAT + 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    fp_mul_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fp_mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MUL_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in multiplier: sign-free zero, the 3.0*2.0 case, otherwise a hash
    function automatic logic [31:0] mul_fn(input logic [31:0] x, input logic [31:0] y);
        if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return 32'h0;
        if (x == 32'h40400000 && y == 32'h40000000) return 32'h40C00000;
        return (x ^ {y[15:0], y[31:16]}) + 32'h9E3779B9;
    endfunction

    logic [31:0] m1, m2;
    always @(posedge clk) begin
        m1 <= mul_fn(bus.mul_a, bus.mul_b);
        m2 <= m1;
    end
    assign bus.mul_result = m2;

    // reference state
    int          rr;
    logic [31:0] last_a, last_b, last_rsp;
    bit          ev   [0:4095];
    int          eid  [0:4095];
    logic [31:0] edat [0:4095];
    logic [N-1:0] obs_ready;
    logic [31:0] obs_data;
    int          obs_cyc;
    int          obs_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        int win, p;
        logic [N-1:0] exp_ready;
        logic exp_busy;
        @(negedge clk);
        if (rst_n) begin
            rr = 0; last_a = 0; last_b = 0; last_rsp = 0;
            for (int j = cyc; j < cyc + 8; j++) ev[j] = 1'b0;
        end
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        p = 0;
`else
        p = rr;
`endif
        win = -1;
        for (int n = 0; n < N; n++)
            if (win < 0 && bus.req_valid[(p + n) % N]) win = (p + n) % N;
        exp_ready = '0;
        if (win >= 0 && !bus.hold && !rst_n) exp_ready[win] = 1'b1;
        exp_busy = 1'b0;
        for (int j = cyc; j < cyc + RSP_DLY; j++) exp_busy |= ev[j];

        obs_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), ev[cyc] ? (32'd1 << eid[cyc]) : 32'd0);
        if (ev[cyc]) last_rsp = edat[cyc];
        chk("rsp_data", bus.rsp_data, last_rsp);
        chk("mul_a", bus.mul_a, last_a);
        chk("mul_b", bus.mul_b, last_b);
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        if (bus.rsp_valid != '0) begin
            obs_data = bus.rsp_data;
            obs_cyc  = cyc;
            for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) obs_id = i;
        end

        if (exp_ready != '0) begin
            last_a = bus.req_a[win*DW +: DW];
            last_b = bus.req_b[win*DW +: DW];
            ev[cyc + RSP_DLY]   = 1'b1;
            eid[cyc + RSP_DLY]  = win;
            edat[cyc + RSP_DLY] = mul_fn(last_a, last_b);
            rr = (win + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic h);
        bus.req_valid = v;
        bus.hold      = h;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = $urandom;
            bus.req_b[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    int hs_cyc;
    int g;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        for (int j = 0; j < 4096; j++) ev[j] = 1'b0;
        rr = 0; last_a = 0; last_b = 0; last_rsp = 0;
        obs_data = 0; obs_cyc = -1; obs_id = -1;
        rst_n = 1'b1;
        drive('0, 1'b0);
        @(posedge clk); #1;
        tick();                       // reset state
        rst_n = 1'b0;

        // single request: 3.0 * 2.0 from requester 2
        drive(4'b0100, 1'b0);
        bus.req_a[2*DW +: DW] = 32'h40400000;
        bus.req_b[2*DW +: DW] = 32'h40000000;
        hs_cyc = cyc;
        tick();
        drive('0, 1'b0);
        repeat (6) tick();
        chk("single_data", obs_data, 32'h40C00000);
        chk("single_id", 32'(obs_id), 32'd2);
        chk("single_lat", 32'(obs_cyc - hs_cyc), 32'(RSP_DLY));

        // full contention rotates from requester 0
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive('1, 1'b0);
            tick();
            g = -1;
            for (int i = 0; i < N; i++) if (obs_ready[i]) g = i;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            chk("rotation", 32'(g), 32'(k % N));
`endif
        end
        drive('0, 1'b0);
        repeat (5) tick();

        // hold with requesters 1 and 3, products in flight
        do_reset();
        drive(4'b1111, 1'b0);
        tick();
        drive(4'b1010, 1'b1);
        repeat (3) tick();
        drive(4'b1010, 1'b0);
        tick();
        chk("hold_first", 32'(obs_ready), 32'b0010);
        tick();
        drive('0, 1'b0);
        repeat (5) tick();

        // reset while two products are in flight
        drive(4'b0011, 1'b0);
        repeat (2) tick();
        drive('0, 1'b0);
        do_reset();
        repeat (5) tick();

        // zero operand passthrough to requester 1
        drive(4'b0010, 1'b0);
        bus.req_a[1*DW +: DW] = 32'h00000000;
        bus.req_b[1*DW +: DW] = 32'hC1560000;
        tick();
        obs_data = 32'hFFFFFFFF;
        drive('0, 1'b0);
        repeat (5) tick();
        chk("zero_data", obs_data, 32'h0);
        chk("zero_id", 32'(obs_id), 32'd1);

        // requesters 0 and 2 continuously valid, then 0 drops
        drive(4'b0101, 1'b0);
        repeat (6) tick();
        drive(4'b0100, 1'b0);
        repeat (2) tick();

        // random traffic with occasional hold and reset
        for (int k = 0; k < 300; k++) begin
            drive(N'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) bus.req_a[$urandom_range(0, N-1)*DW +: DW] = 32'h0;
            if ($urandom_range(0, 63) == 0) rst_n = 1'b1;
            tick();
            rst_n = 1'b0;
        end
        drive('0, 1'b0);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
